// File: rtl/mem_bus_arbiter_if.sv
// Interface for mem_bus_arbiter: two requester ports (cpu_*, dma_*) and the
// shared memory bus (mem_*, chip selects, bus_error, grant_dma).
//   slave  : the arbiter's view (serves cpu/dma requests, drives the memory bus)
//   master : the environment's view (requesters and memory devices)
interface mem_bus_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 2;

  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [SIZE_W-1:0] cpu_size;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  // DMA requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [SIZE_W-1:0] dma_size;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  // Shared memory bus
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_write_en;
  logic [SIZE_W-1:0] mem_size;
  logic              ram_select;
  logic              rom_select;
  logic              perif_select;
  logic              unused_select;
  logic              bus_error;
  logic              grant_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_size,
    output dma_ack, dma_rdata,
    output mem_address, mem_wdata, mem_write_en, mem_size,
    output ram_select, rom_select, perif_select, unused_select,
    output bus_error, grant_dma,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_size,
    input  dma_ack, dma_rdata,
    input  mem_address, mem_wdata, mem_write_en, mem_size,
    input  ram_select, rom_select, perif_select, unused_select,
    input  bus_error, grant_dma,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the CPU control unit and a
// DMA port. Round-robin arbitration (CPU wins the first tie after reset),
// address-region decode with per-region wait states, registered chip selects,
// registered read data and a one-cycle ack per transfer.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-low reset
//   bus    - mem_bus_arbiter_if.slave: cpu_*/dma_* request ports and the
//            shared mem_* bus, chip selects, bus_error, grant_dma
module mem_bus_arbiter #(
  parameter int unsigned ROM_WAIT   = 0,
  parameter int unsigned RAM_WAIT   = 1,
  parameter int unsigned PERIF_WAIT = 2
) (
  input  logic               clock,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  // Enum value doubles as the bit index into the one-hot select vector.
  typedef enum logic [1:0] {R_ROM, R_RAM, R_PERIF, R_UNUSED} region_t;

  function automatic region_t decode_region(input logic [ADDR_W-1:0] a);
    case (a[31:28])
      4'h0:    return R_ROM;
      4'h1:    return R_RAM;
      4'h2:    return R_PERIF;
      default: return R_UNUSED;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] region_wait(input region_t r);
    case (r)
      R_ROM:   return CNT_W'(ROM_WAIT);
      R_RAM:   return CNT_W'(RAM_WAIT);
      R_PERIF: return CNT_W'(PERIF_WAIT);
      default: return '0;
    endcase
  endfunction

  state_t              state_q, state_d;
  region_t             region_q, region_d;
  logic                grant_q, grant_d;          // 1 = DMA
  logic                last_grant_q, last_grant_d; // 1 = DMA
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;              // {unused, perif, ram, rom}
  logic                wen_q, wen_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                bus_error_q, bus_error_d;

  // Requester selection and its payload, as seen in IDLE
  logic                pick_dma;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_we;
  logic [SIZE_W-1:0]   req_size;
  region_t             req_region;
  logic [DATA_W-1:0]   rd_value;

  // Round-robin: a tie goes to the master that was not served last.
  always_comb begin
    pick_dma   = bus.dma_req && (!bus.cpu_req || !last_grant_q);
    req_addr   = pick_dma ? bus.dma_addr  : bus.cpu_addr;
    req_wdata  = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
    req_we     = pick_dma ? bus.dma_we    : bus.cpu_we;
    req_size   = pick_dma ? bus.dma_size  : bus.cpu_size;
    req_region = decode_region(req_addr);
    rd_value   = we_q ? '0 : bus.mem_rdata;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    wen_d        = wen_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    cpu_rdata_d  = '0;
    dma_rdata_d  = '0;
    bus_error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          grant_d  = pick_dma;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          we_d     = req_we;
          size_d   = req_size;
          region_d = req_region;
          cnt_d    = region_wait(req_region);
          sel_d    = SEL_W'(1) << req_region;
          // Writes to ROM or unmapped space never reach the bus.
          wen_d    = req_we && (req_region == R_RAM || req_region == R_PERIF);
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          sel_d       = '0;
          wen_d       = 1'b0;
          bus_error_d = (region_q == R_UNUSED) || (region_q == R_ROM && we_q);
          if (grant_q) begin
            dma_ack_d   = 1'b1;
            dma_rdata_d = rd_value;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = rd_value;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      region_q     <= R_ROM;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      wen_q        <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      wen_q        <= wen_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign bus.mem_address   = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_size      = size_q;
  assign bus.mem_write_en  = wen_q;
  assign bus.rom_select    = sel_q[0];
  assign bus.ram_select    = sel_q[1];
  assign bus.perif_select  = sel_q[2];
  assign bus.unused_select = sel_q[3];
  assign bus.cpu_ack       = cpu_ack_q;
  assign bus.cpu_rdata     = cpu_rdata_q;
  assign bus.dma_ack       = dma_ack_q;
  assign bus.dma_rdata     = dma_rdata_q;
  assign bus.bus_error     = bus_error_q;
  assign bus.grant_dma     = grant_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, compared against a transaction-level model of the
// arbitration, region map, wait states and response rules.
module tb_mem_bus_arbiter;

  localparam int unsigned ROM_WAIT   = 0;
  localparam int unsigned RAM_WAIT   = 1;
  localparam int unsigned PERIF_WAIT = 2;

  logic clock;
  logic reset;
  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(
    .ROM_WAIT  (ROM_WAIT),
    .RAM_WAIT  (RAM_WAIT),
    .PERIF_WAIT(PERIF_WAIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory device model: fixed value when forced, otherwise address-derived.
  logic        use_fixed;
  logic [63:0] fixed_rdata;

  function automatic logic [63:0] dev_data(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a};
  endfunction

  function automatic logic [63:0] dev_expect(input logic [31:0] a);
    return use_fixed ? fixed_rdata : dev_data(a);
  endfunction

  assign bus.mem_rdata = use_fixed ? fixed_rdata : dev_data(bus.mem_address);

  logic [3:0] obs_sel;
  assign obs_sel = {bus.unused_select, bus.perif_select, bus.ram_select, bus.rom_select};

  int n_vec;
  int n_err;
  bit m_last_dma;   // model: 1 when DMA was served last

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input bit we, input logic [31:0] a, input logic [63:0] wd, input logic [1:0] sz);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_size = sz;
  endtask

  task automatic set_dma(input bit we, input logic [31:0] a, input logic [63:0] wd, input logic [1:0] sz);
    bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = wd; bus.dma_size = sz;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [3:0]  hi;
    r  = $urandom_range(0, 4);
    hi = (r == 4) ? 4'(3 + $urandom_range(0, 12)) : 4'(r);
    return {hi, 28'($urandom)};
  endfunction

  // Granted master changes its payload (and may drop req) after the grant.
  task automatic scramble_master(input bit is_dma);
    if (is_dma) begin
      bus.dma_addr = $urandom; bus.dma_wdata = {$urandom, $urandom};
      bus.dma_we = ~bus.dma_we; bus.dma_size = 2'($urandom);
      if ($urandom_range(0, 1) == 1) bus.dma_req = 1'b0;
    end else begin
      bus.cpu_addr = $urandom; bus.cpu_wdata = {$urandom, $urandom};
      bus.cpu_we = ~bus.cpu_we; bus.cpu_size = 2'($urandom);
      if ($urandom_range(0, 1) == 1) bus.cpu_req = 1'b0;
    end
  endtask

  // Called at a negedge of an IDLE cycle with at least one request raised.
  // Runs one whole transfer and returns at the negedge of the following IDLE.
  task automatic step_txn(input bit scramble, output logic obs_grant);
    bit          w_dma, we, ewen, eberr;
    logic [31:0] a;
    logic [63:0] wd, erd;
    logic [1:0]  sz;
    logic [3:0]  esel;
    int unsigned waitc;
    w_dma = bus.dma_req && (!bus.cpu_req || !m_last_dma);
    if (w_dma) begin a = bus.dma_addr; wd = bus.dma_wdata; we = bus.dma_we; sz = bus.dma_size; end
    else       begin a = bus.cpu_addr; wd = bus.cpu_wdata; we = bus.cpu_we; sz = bus.cpu_size; end
    case (a[31:28])
      4'h0:    begin waitc = ROM_WAIT;   esel = 4'b0001; end
      4'h1:    begin waitc = RAM_WAIT;   esel = 4'b0010; end
      4'h2:    begin waitc = PERIF_WAIT; esel = 4'b0100; end
      default: begin waitc = 0;          esel = 4'b1000; end
    endcase
    ewen  = we && (esel[1] || esel[2]);
    eberr = esel[3] || (esel[0] && we);
    erd   = we ? 64'h0 : dev_expect(a);
    obs_grant = 1'bx;

    @(posedge clock); #1;
    if (scramble) scramble_master(w_dma);
    for (int unsigned i = 0; i <= waitc; i++) begin
      @(negedge clock);
      if (i == 0) obs_grant = bus.grant_dma;
      chk("access_sel",   64'(obs_sel),          64'(esel));
      chk("access_wen",   64'(bus.mem_write_en), 64'(ewen));
      chk("access_addr",  64'(bus.mem_address),  64'(a));
      chk("access_wdata", bus.mem_wdata,         wd);
      chk("access_size",  64'(bus.mem_size),     64'(sz));
      chk("access_grant", 64'(bus.grant_dma),    64'(w_dma));
      chk("access_acks",  64'({bus.cpu_ack, bus.dma_ack}), 64'(0));
    end
    @(negedge clock);
    chk("resp_sel",     64'(obs_sel),          64'(0));
    chk("resp_wen",     64'(bus.mem_write_en), 64'(0));
    chk("resp_cpu_ack", 64'(bus.cpu_ack),      64'(!w_dma));
    chk("resp_dma_ack", 64'(bus.dma_ack),      64'(w_dma));
    chk("resp_rdata",   w_dma ? bus.dma_rdata : bus.cpu_rdata, erd);
    chk("resp_berr",    64'(bus.bus_error),    64'(eberr));
    if (w_dma) bus.dma_req = 1'b0; else bus.cpu_req = 1'b0;
    m_last_dma = w_dma;
    @(negedge clock);
    chk("idle_sel",  64'(obs_sel), 64'(0));
    chk("idle_misc", 64'({bus.cpu_ack, bus.dma_ack, bus.bus_error, bus.mem_write_en}), 64'(0));
  endtask

  logic g;

  initial begin
    n_vec = 0; n_err = 0; m_last_dma = 1'b1;
    use_fixed = 1'b0; fixed_rdata = '0;
    reset = 1'b0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_size = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0; bus.dma_size = 0;
    repeat (3) @(negedge clock);
    chk("reset_sel",  64'(obs_sel), 64'(0));
    chk("reset_outs", 64'({bus.cpu_ack, bus.dma_ack, bus.bus_error, bus.mem_write_en, bus.grant_dma}), 64'(0));
    chk("reset_addr", 64'(bus.mem_address), 64'(0));
    reset = 1'b1;
    @(negedge clock);

    // ROM read with fixed device data
    use_fixed = 1'b1; fixed_rdata = 64'hDEAD;
    set_cpu(1'b0, 32'h0000_0010, 64'h0, 2'd3);
    step_txn(1'b0, g);
    chk("t1_grant", 64'(g), 64'(0));
    use_fixed = 1'b0;

    // DMA write to RAM
    set_dma(1'b1, 32'h1000_0008, 64'h55, 2'd0);
    step_txn(1'b0, g);
    chk("t2_grant", 64'(g), 64'(1));

    // Simultaneous requests alternate CPU, DMA, CPU, DMA
    for (int i = 0; i < 4; i++) begin
      if (!bus.cpu_req) set_cpu(1'b0, rand_addr(), {$urandom, $urandom}, 2'($urandom));
      if (!bus.dma_req) set_dma(1'b0, rand_addr(), {$urandom, $urandom}, 2'($urandom));
      step_txn(1'b0, g);
      chk("t3_rr_grant", 64'(g), 64'(i % 2));
    end
    while (bus.cpu_req || bus.dma_req) step_txn(1'b0, g);

    // ROM write and UNUSED read: no write strobe, bus_error with ack
    set_cpu(1'b1, 32'h0000_0000, 64'h1234_5678, 2'd3);
    step_txn(1'b0, g);
    set_cpu(1'b0, 32'h3000_0000, 64'h0, 2'd3);
    step_txn(1'b0, g);

    // Payload changes after grant are ignored
    set_cpu(1'b0, 32'h2000_0100, 64'h0, 2'd1);
    step_txn(1'b1, g);
    bus.cpu_req = 1'b0;

    // Reset during a PERIF access
    set_cpu(1'b0, 32'h2000_0004, 64'h0, 2'd3);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t5_perif_c1", 64'(obs_sel), 64'b0100);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_sel",  64'(obs_sel), 64'(0));
    chk("t5_rst_outs", 64'({bus.cpu_ack, bus.dma_ack, bus.bus_error, bus.mem_write_en, bus.grant_dma}), 64'(0));
    chk("t5_rst_addr", 64'(bus.mem_address), 64'(0));
    bus.cpu_req = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("t5_no_ack", 64'({bus.cpu_ack, bus.dma_ack}), 64'(0));
    end
    reset = 1'b1; m_last_dma = 1'b1;
    @(negedge clock);
    chk("t5_idle", 64'({obs_sel, bus.cpu_ack, bus.dma_ack}), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if (!bus.cpu_req && $urandom_range(0, 2) != 0)
        set_cpu(1'($urandom), rand_addr(), {$urandom, $urandom}, 2'($urandom));
      if (!bus.dma_req && $urandom_range(0, 2) != 0)
        set_dma(1'($urandom), rand_addr(), {$urandom, $urandom}, 2'($urandom));
      if (!bus.cpu_req && !bus.dma_req)
        set_cpu(1'($urandom), rand_addr(), {$urandom, $urandom}, 2'($urandom));
      step_txn($urandom_range(0, 1) == 1, g);
    end
    while (bus.cpu_req || bus.dma_req) step_txn(1'b0, g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
